// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin arbiters that lock an output to one
// input for a whole packet; drives crossbar selects, output strobes and pops.
module switch_allocator #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned SEL_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS*N_PORTS-1:0] req_i,
  input  logic [N_PORTS-1:0]         valid_i,
  input  logic [2*N_PORTS-1:0]       ftype_i,
  input  logic [N_PORTS-1:0]         out_ready_i,
  output logic [SEL_W*N_PORTS-1:0]   sel_o,
  output logic [N_PORTS-1:0]         out_valid_o,
  output logic [N_PORTS-1:0]         rd_en_o,
  output logic [N_PORTS-1:0]         busy_o
);

  localparam logic [SEL_W-1:0] SEL_NONE = '1;
  localparam int unsigned      PTR_LAST = N_PORTS - 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state     [N_PORTS];
  logic [SEL_W-1:0] r_owner     [N_PORTS];
  logic [SEL_W-1:0] r_ptr       [N_PORTS];
  state_t           w_state_nxt [N_PORTS];
  logic [SEL_W-1:0] w_owner_nxt [N_PORTS];
  logic [SEL_W-1:0] w_ptr_nxt   [N_PORTS];

  logic [N_PORTS-1:0] w_eff_req [N_PORTS];  // per input, one-hot over outputs
  logic [N_PORTS-1:0] w_cand    [N_PORTS];  // per output, one bit per input
  logic [N_PORTS-1:0] w_owned;
  logic [N_PORTS-1:0] w_found;
  logic [SEL_W-1:0]   w_winner  [N_PORTS];
  logic [N_PORTS-1:0] w_xfer;
  logic [N_PORTS-1:0] w_xfer_tail;
  int unsigned        w_dist;
  int unsigned        w_best;

  // Keep only the lowest set request bit of each input.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_eff_req[i] = req_i[i*N_PORTS +: N_PORTS] &
                     (~req_i[i*N_PORTS +: N_PORTS] + N_PORTS'(1));
    end
  end

  always_comb begin
    w_owned = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (r_state[j] == S_LOCKED && r_owner[j] == SEL_W'(i)) begin
          w_owned[i] = 1'b1;
        end
      end
    end
  end

  // Candidate: valid header-type head flit, routed here, input not already owned.
  always_comb begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      w_cand[j] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        w_cand[j][i] = valid_i[i] & w_eff_req[i][j] & ftype_i[2*i+1] & ~w_owned[i];
      end
    end
  end

  // Round-robin pick: smallest circular distance from the pointer wins.
  always_comb begin
    w_dist = 0;
    w_best = 0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      w_found[j]  = 1'b0;
      w_winner[j] = '0;
      w_best      = N_PORTS;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        w_dist = i + N_PORTS - 32'(r_ptr[j]);
        if (w_dist >= N_PORTS) begin
          w_dist = w_dist - N_PORTS;
        end
        if (w_cand[j][i] && w_dist < w_best) begin
          w_best      = w_dist;
          w_winner[j] = SEL_W'(i);
          w_found[j]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_o       = {N_PORTS{SEL_NONE}};
    out_valid_o = '0;
    rd_en_o     = '0;
    w_xfer      = '0;
    w_xfer_tail = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (r_state[j] == S_LOCKED) begin
        sel_o[j*SEL_W +: SEL_W] = r_owner[j];
        for (int unsigned i = 0; i < N_PORTS; i++) begin
          if (r_owner[j] == SEL_W'(i)) begin
            w_xfer[j]      = valid_i[i] & out_ready_i[j];
            w_xfer_tail[j] = valid_i[i] & out_ready_i[j] & ftype_i[2*i];
            rd_en_o[i]     = rd_en_o[i] | (valid_i[i] & out_ready_i[j]);
          end
        end
        out_valid_o[j] = w_xfer[j];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      busy_o[j] = (r_state[j] == S_LOCKED);
    end
  end

  // Next state: lock on a grant, release when a tail-type flit transfers.
  always_comb begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      w_state_nxt[j] = r_state[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
      unique case (r_state[j])
        S_IDLE: begin
          if (w_found[j]) begin
            w_state_nxt[j] = S_LOCKED;
            w_owner_nxt[j] = w_winner[j];
            w_ptr_nxt[j]   = (w_winner[j] == SEL_W'(PTR_LAST)) ? '0
                                                               : w_winner[j] + SEL_W'(1);
          end
        end
        S_LOCKED: begin
          if (w_xfer_tail[j]) begin
            w_state_nxt[j] = S_IDLE;
          end
        end
        default: w_state_nxt[j] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        r_state[j] <= S_IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: directed scenarios plus random packet
// traffic, checked every cycle against a packet-level reference model.
module tb_switch_allocator;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] req_i;
  logic [4:0]  valid_i;
  logic [9:0]  ftype_i;
  logic [4:0]  out_ready_i;
  logic [14:0] sel_o;
  logic [4:0]  out_valid_o;
  logic [4:0]  rd_en_o;
  logic [4:0]  busy_o;

  always #5 clk = ~clk;

  switch_allocator #(.N_PORTS(5), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .valid_i(valid_i), .ftype_i(ftype_i),
    .out_ready_i(out_ready_i), .sel_o(sel_o), .out_valid_o(out_valid_o),
    .rd_en_o(rd_en_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [14:0] sel;
    logic [4:0]  ov;
    logic [4:0]  rd;
    logic [4:0]  busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: per output lock flag, owning input, rr pointer.
  bit m_locked[N];
  int m_owner[N];
  int m_ptr[N];

  logic [24:0] s_req;
  logic [4:0]  s_valid;
  logic [9:0]  s_ftype;
  logic [4:0]  s_ready;
  logic [4:0]  last_rd;

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_locked[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    int eff[N];
    bit owned[N];
    bit rel[N];
    int win;
    logic [1:0] ft;
    e = '0;
    e.sel = '1;
    for (int i = 0; i < N; i++) begin
      eff[i] = -1;
      for (int j = N - 1; j >= 0; j--) if (req_i[5*i+j]) eff[i] = j;
      owned[i] = 0;
    end
    for (int j = 0; j < N; j++) if (m_locked[j]) owned[m_owner[j]] = 1;
    for (int j = 0; j < N; j++) begin
      rel[j] = 0;
      if (m_locked[j]) begin
        e.busy[j] = 1'b1;
        e.sel[3*j +: 3] = 3'(m_owner[j]);
        if (valid_i[m_owner[j]] && out_ready_i[j]) begin
          e.ov[j] = 1'b1;
          e.rd[m_owner[j]] = 1'b1;
          ft = ftype_i[2*m_owner[j] +: 2];
          if (ft == 2'b01 || ft == 2'b11) rel[j] = 1;
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      if (m_locked[j]) begin
        if (rel[j]) m_locked[j] = 0;
      end else begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[j] + k) % N;
          ft = ftype_i[2*c +: 2];
          if (win < 0 && valid_i[c] && eff[c] == j && (ft == 2'b10 || ft == 2'b11) && !owned[c])
            win = c;
        end
        if (win >= 0) begin
          m_locked[j] = 1; m_owner[j] = win; m_ptr[j] = (win + 1) % N;
        end
      end
    end
  endtask

  // Apply staged inputs for one cycle and queue the expected response.
  task automatic step();
    exp_t e;
    @(negedge clk);
    req_i = s_req; valid_i = s_valid; ftype_i = s_ftype; out_ready_i = s_ready;
    model_step(e);
    exp_q.push_back(e);
    last_rd = e.rd;
    for (int i = 0; i < N; i++) if (e.rd[i] && s_ftype[2*i]) s_valid[i] = 1'b0;
  endtask

  task automatic put(input int i, input int dest, input logic [1:0] ft);
    s_req[5*i +: 5]   = 5'(1 << dest);
    s_ftype[2*i +: 2] = ft;
    s_valid[i]        = 1'b1;
  endtask

  task automatic clr();
    s_req = '0; s_valid = '0; s_ftype = '0; s_ready = '1;
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (sel_o !== 15'h7fff || out_valid_o !== 5'd0 || rd_en_o !== 5'd0 || busy_o !== 5'd0) begin
      n_err++;
      $display("FAIL %s: sel=%h ov=%b rd=%b busy=%b required sel=7fff ov=0 rd=0 busy=0",
               name, sel_o, out_valid_o, rd_en_o, busy_o);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if ({sel_o, out_valid_o, rd_en_o, busy_o} !== e) begin
          n_err++;
          $display("FAIL cycle_out @%0t: sel=%h ov=%b rd=%b busy=%b required sel=%h ov=%b rd=%b busy=%b",
                   $time, sel_o, out_valid_o, rd_en_o, busy_o, e.sel, e.ov, e.rd, e.busy);
        end
      end
    end
  end

  int          src_len[N];
  int          src_pos[N];
  int          src_dest[N];
  bit          src_act[N];
  logic [4:0]  src_extra[N];

  initial begin
    rst = 1'b0;
    clr();
    req_i = '0; valid_i = '0; ftype_i = '0; out_ready_i = '1;
    last_rd = '0;
    model_reset();
    #3;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b1;

    // Single-flit packet, input 1 -> L.
    clr(); put(1, 0, 2'b11);
    repeat (4) step();

    // Three-flit packet input 0 -> S with a stalled body.
    clr(); put(0, 3, 2'b10);
    step(); step();
    put(0, 3, 2'b00); s_ready[3] = 1'b0; step();
    s_ready[3] = 1'b1; step();
    put(0, 3, 2'b01); step();
    step();

    // Contention on E from inputs 0, 2, 4.
    clr(); put(0, 1, 2'b11); put(2, 1, 2'b11); put(4, 1, 2'b11);
    repeat (8) step();

    // Pointer wrap on W: move ptr to 4, then inputs 0 and 3 contend.
    clr(); put(3, 2, 2'b11);
    repeat (3) step();
    put(0, 2, 2'b11); put(3, 2, 2'b11);
    repeat (6) step();

    // Parallel locks: input 1 -> N, input 3 -> W.
    clr(); put(1, 4, 2'b11); put(3, 2, 2'b11);
    repeat (3) step();

    // Reset during a body flit, then a fresh packet.
    clr(); put(2, 1, 2'b10);
    step(); step();
    put(2, 1, 2'b00);
    step(); step();
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_packet");
    model_reset();
    clr();
    @(negedge clk);
    rst = 1'b1;
    put(2, 1, 2'b10); step(); step();
    put(2, 1, 2'b01); step();
    step(); step();

    // Random packet traffic.
    clr();
    for (int i = 0; i < N; i++) src_act[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!src_act[i] && $urandom_range(0, 3) == 0) begin
          src_act[i]   = 1;
          src_len[i]   = int'($urandom_range(1, 4));
          src_pos[i]   = 0;
          src_dest[i]  = int'($urandom_range(0, 4));
          src_extra[i] = '0;
          if ($urandom_range(0, 3) == 0)
            for (int b = src_dest[i] + 1; b < N; b++) src_extra[i][b] = 1'($urandom_range(0, 1));
        end
        if (src_act[i]) begin
          logic [1:0] ft;
          if (src_len[i] == 1)                    ft = 2'b11;
          else if (src_pos[i] == 0)               ft = 2'b10;
          else if (src_pos[i] == src_len[i] - 1)  ft = 2'b01;
          else                                    ft = 2'b00;
          s_req[5*i +: 5]   = 5'(1 << src_dest[i]) | src_extra[i];
          s_ftype[2*i +: 2] = ft;
          s_valid[i]        = ($urandom_range(0, 9) < 8);
        end else begin
          s_req[5*i +: 5]   = 5'($urandom);
          s_ftype[2*i +: 2] = 2'($urandom);
          s_valid[i]        = 1'b0;
        end
      end
      for (int j = 0; j < N; j++) s_ready[j] = ($urandom_range(0, 3) != 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (last_rd[i]) begin
          src_pos[i]++;
          if (src_pos[i] >= src_len[i]) src_act[i] = 0;
        end
      end
    end

    @(negedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
